// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 scan-code sequencer.
//   - set-2 prefix and receiver error byte constants
//   - decoder state encoding
//   - 10-bit key event type {brk, ext, code}
package ps2_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_evt_t;

  // A byte that opens or extends a prefix sequence.
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: synchronous FIFO of ps2_evt_t entries.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write request and entry; accepted when not full or when
//                 a pop happens in the same cycle
//   pop           read request; honoured only when not empty
//   rdata         head entry, driven straight from storage
//   full, empty   occupancy flags
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  ps2_evt_t wdata,
  input  logic     pop,
  output ps2_evt_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ps2_evt_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            do_push;
  logic            do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});
  assign rdata = mem_q[rd_ptr_q];

  // A full FIFO still takes a write when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
      end
    end
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: resolves set-2 E0/F0 prefixes from the PS/2 byte receiver
// into key events, suppresses typematic repeats, tracks the held key and a
// press counter, and queues events in ps2_evt_fifo for a valid/ready consumer.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rx_data, rx_ready             receiver byte and its one-cycle strobe
//   evt_valid, evt_ready          consumer handshake on the FIFO head
//   evt_code, evt_ext, evt_break  head event fields
//   key_down, cur_code, cur_ext   currently held key state
//   press_count                   accepted make events, wrapping
//   overflow, proto_err           sticky error flags
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             key_down,
  output logic [7:0]       cur_code,
  output logic             cur_ext,
  output logic [CNT_W-1:0] press_count,
  output logic             overflow,
  output logic             proto_err
);

  ps2_state_e       state_q, state_d;
  logic             key_down_q, key_down_d;
  logic [7:0]       cur_code_q, cur_code_d;
  logic             cur_ext_q, cur_ext_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;
  logic             overflow_q, overflow_d;
  logic             proto_err_q, proto_err_d;

  logic             is_make;
  logic             is_brk;
  logic             evt_ext_flag;
  logic             push;
  ps2_evt_t         push_evt;
  ps2_evt_t         head_evt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  // Prefix decoder: classifies each strobed byte and advances the state.
  always_comb begin
    state_d      = state_q;
    proto_err_d  = proto_err_q;
    is_make      = 1'b0;
    is_brk       = 1'b0;
    evt_ext_flag = 1'b0;
    if (rx_ready) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == PS2_EXT) begin
            state_d = S_EXT;
          end else if (rx_data == PS2_BRK) begin
            state_d = S_BRK;
          end else if ((rx_data == PS2_ERR0) || (rx_data == PS2_ERR1)) begin
            state_d = S_IDLE;
          end else begin
            is_make = 1'b1;
          end
        end
        S_EXT: begin
          if (rx_data == PS2_BRK) begin
            state_d = S_EXT_BRK;
          end else if (rx_data == PS2_EXT) begin
            state_d = S_EXT;
          end else begin
            is_make      = 1'b1;
            evt_ext_flag = 1'b1;
            state_d      = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: begin
          // A prefix inside a break sequence is malformed; abandon it.
          if (is_prefix(rx_data)) begin
            proto_err_d = 1'b1;
          end else begin
            is_brk       = 1'b1;
            evt_ext_flag = (state_q == S_EXT_BRK);
          end
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Key tracking, repeat suppression and event generation.
  always_comb begin
    key_down_d    = key_down_q;
    cur_code_d    = cur_code_q;
    cur_ext_d     = cur_ext_q;
    press_count_d = press_count_q;
    push          = 1'b0;
    push_evt      = '{brk: is_brk, ext: evt_ext_flag, code: rx_data};
    if (is_make) begin
      // Same key still held: typematic repeat, nothing to report.
      if (key_down_q && (cur_ext_q == evt_ext_flag) && (cur_code_q == rx_data)) begin
        push = 1'b0;
      end else begin
        push          = 1'b1;
        key_down_d    = 1'b1;
        cur_code_d    = rx_data;
        cur_ext_d     = evt_ext_flag;
        press_count_d = press_count_q + CNT_W'(1);
      end
    end else if (is_brk) begin
      push = 1'b1;
      if ((cur_ext_q == evt_ext_flag) && (cur_code_q == rx_data)) begin
        key_down_d = 1'b0;
      end else begin
        key_down_d = key_down_q;
      end
    end else begin
      push = 1'b0;
    end
  end

  assign pop = ~fifo_empty & evt_ready;

  // A push that meets a full FIFO with no pop is lost.
  always_comb begin
    if (push && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Decoder and key-state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      key_down_q    <= 1'b0;
      cur_code_q    <= 8'h00;
      cur_ext_q     <= 1'b0;
      press_count_q <= {CNT_W{1'b0}};
      overflow_q    <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_down_q    <= key_down_d;
      cur_code_q    <= cur_code_d;
      cur_ext_q     <= cur_ext_d;
      press_count_q <= press_count_d;
      overflow_q    <= overflow_d;
      proto_err_q   <= proto_err_d;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_evt),
    .pop   (pop),
    .rdata (head_evt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid   = ~fifo_empty;
  assign evt_code    = head_evt.code;
  assign evt_ext     = head_evt.ext;
  assign evt_break   = head_evt.brk;
  assign key_down    = key_down_q;
  assign cur_code    = cur_code_q;
  assign cur_ext     = cur_ext_q;
  assign press_count = press_count_q;
  assign overflow    = overflow_q;
  assign proto_err   = proto_err_q;

endmodule
